// File: rtl/fb_ctrl_pkg.sv
// fb_ctrl_pkg: frame sequencing states shared by the display and renderer control logic.
package fb_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, WAIT_SWAP} fb_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: registers an accepted pixel into a linear write address, data and write
// strobe; pixels outside the screen are still consumed but never strobed.
module fb_addr_gen #(
   parameter int W  = 160,
   parameter int H  = 120,
   parameter int IW = 4,
   parameter int AW = 15,
   parameter int XW = 8,
   parameter int YW = 7
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          accept_i,
   input  logic [XW-1:0] px_x_i,
   input  logic [YW-1:0] px_y_i,
   input  logic [IW-1:0] px_index_i,
   output logic          we_o,
   output logic [AW-1:0] addr_o,
   output logic [IW-1:0] data_o
);
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [IW-1:0] data_q;
   logic          in_bounds;
   assign in_bounds = (int'(px_x_i) < W) && (int'(px_y_i) < H);
   assign we_d      = accept_i & in_bounds;
   assign addr_d    = AW'(px_y_i) * AW'(W) + AW'(px_x_i);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q <= we_d;
         if (accept_i) begin
            addr_q <= addr_d;
            data_q <= px_index_i;
         end
      end
   end
   assign we_o   = we_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
endmodule

// File: rtl/framebuffer_write_ctrl.sv
// framebuffer_write_ctrl: per frame clears the back buffer, streams rasterizer pixels
// into it, then swaps front/back on the next display vsync.
module framebuffer_write_ctrl
   import fb_ctrl_pkg::*;
#(
   parameter int  SCREEN_WIDTH  = 160,
   parameter int  SCREEN_HEIGHT = 120,
   parameter int  INDEX_WIDTH   = 4,
   localparam int BUFFER_SIZE   = SCREEN_WIDTH * SCREEN_HEIGHT,
   localparam int ADDR_WIDTH    = $clog2(BUFFER_SIZE),
   localparam int X_WIDTH       = $clog2(SCREEN_WIDTH),
   localparam int Y_WIDTH       = $clog2(SCREEN_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   frame_start,
   input  logic [INDEX_WIDTH-1:0] clear_index,
   input  logic                   px_valid,
   output logic                   px_ready,
   input  logic [X_WIDTH-1:0]     px_x,
   input  logic [Y_WIDTH-1:0]     px_y,
   input  logic [INDEX_WIDTH-1:0] px_index,
   input  logic                   frame_done,
   input  logic                   vsync_start,
   output logic                   fb_we,
   output logic [ADDR_WIDTH-1:0]  fb_addr,
   output logic [INDEX_WIDTH-1:0] fb_data,
   output logic                   fb0_we,
   output logic                   fb1_we,
   output logic                   display_sel,
   output logic                   busy,
   output logic                   swap_done
);
   fb_state_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
   logic [INDEX_WIDTH-1:0] clr_q, clr_d;
   logic                   sel_q, sel_d;
   logic                   swap_q, swap_d;
   logic                   clearing, accept, gen_we;
   logic [ADDR_WIDTH-1:0]  gen_addr;
   logic [INDEX_WIDTH-1:0] gen_data;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clr_q   <= '0;
         sel_q   <= 1'b0;
         swap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         sel_q   <= sel_d;
         swap_q  <= swap_d;
      end
   end
   // Pulses arriving in a state that does not consume them are simply dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      sel_d   = sel_q;
      swap_d  = 1'b0;
      case (state_q)
         IDLE: if (frame_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
            clr_d   = clear_index;
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_WIDTH'(BUFFER_SIZE - 1)) state_d = DRAW;
         end
         DRAW: if (frame_done) state_d = WAIT_SWAP;
         WAIT_SWAP: if (vsync_start) begin
            state_d = IDLE;
            sel_d   = ~sel_q;
            swap_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   assign clearing = (state_q == CLEAR);
   assign px_ready = (state_q == DRAW);
   assign accept   = px_valid & px_ready;
   fb_addr_gen #(
      .W (SCREEN_WIDTH),
      .H (SCREEN_HEIGHT),
      .IW(INDEX_WIDTH),
      .AW(ADDR_WIDTH),
      .XW(X_WIDTH),
      .YW(Y_WIDTH)
   ) u_addr_gen (
      .clk       (clk),
      .rstn      (rstn),
      .accept_i  (accept),
      .px_x_i    (px_x),
      .px_y_i    (px_y),
      .px_index_i(px_index),
      .we_o      (gen_we),
      .addr_o    (gen_addr),
      .data_o    (gen_data)
   );
   // The registered pixel path can only be active in DRAW or its one drain cycle.
   assign fb_we       = clearing | gen_we;
   assign fb_addr     = clearing ? cnt_q : gen_addr;
   assign fb_data     = clearing ? clr_q : gen_data;
   assign fb0_we      = fb_we & sel_q;
   assign fb1_we      = fb_we & ~sel_q;
   assign display_sel = sel_q;
   assign busy        = (state_q != IDLE);
   assign swap_done   = swap_q;
endmodule

// File: tb/tb_framebuffer_write_ctrl.sv
// tb_framebuffer_write_ctrl: directed and randomized frames checked against a
// pixel-level reference model computed from screen geometry.
module tb_framebuffer_write_ctrl;
   localparam int W  = 160;
   localparam int H  = 120;
   localparam int SZ = W * H;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        frame_start = 1'b0;
   logic [3:0]  clear_index = '0;
   logic        px_valid = 1'b0;
   logic        px_ready;
   logic [7:0]  px_x = '0;
   logic [6:0]  px_y = '0;
   logic [3:0]  px_index = '0;
   logic        frame_done = 1'b0;
   logic        vsync_start = 1'b0;
   logic        fb_we, fb0_we, fb1_we, display_sel, busy, swap_done;
   logic [14:0] fb_addr;
   logic [3:0]  fb_data;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        m_sel = 1'b0;
   always #5 clk = ~clk;
   framebuffer_write_ctrl dut (
      .clk(clk), .rstn(rstn), .frame_start(frame_start), .clear_index(clear_index),
      .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
      .px_index(px_index), .frame_done(frame_done), .vsync_start(vsync_start),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb0_we(fb0_we),
      .fb1_we(fb1_we), .display_sel(display_sel), .busy(busy), .swap_done(swap_done)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(px_ready), 0);
      chk({tag, "_we"}, 32'(fb_we), 0);
      chk({tag, "_addr"}, 32'(fb_addr), 0);
      chk({tag, "_data"}, 32'(fb_data), 0);
      chk({tag, "_sel"}, 32'(display_sel), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_swap"}, 32'(swap_done), 0);
   endtask
   // Full clear pass; stray vsync and frame_start pulses are injected mid-clear.
   task automatic run_clear(input logic [3:0] ci);
      int bad = 0;
      clear_index = ci;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      clear_index = ~ci;
      for (int i = 0; i < SZ; i++) begin
         if (!(fb_we === 1'b1 && fb_addr === 15'(i) && fb_data === ci && px_ready === 1'b0
               && fb0_we === m_sel && fb1_we === !m_sel && busy === 1'b1 && swap_done === 1'b0)) begin
            if (bad < 4) chk("clear_write", {fb_we, fb0_we, fb1_we, px_ready, 8'(fb_data), 16'(fb_addr)},
                             {1'b1, m_sel, !m_sel, 1'b0, 8'(ci), 16'(i)});
            bad++;
         end
         vsync_start = (i == 50);
         frame_start = (i == 60);
         tick();
         vsync_start = 1'b0;
         frame_start = 1'b0;
      end
      chk("clear_all_ok", 32'(bad), 0);
      chk("clear_then_ready", 32'(px_ready), 1);
      chk("clear_then_we", 32'(fb_we), 0);
      chk("clear_no_swap", {31'(swap_done), display_sel}, {31'(0), m_sel});
   endtask
   // One DRAW cycle: expected write is derived from geometry alone.
   task automatic draw_step(input logic v, input int x, input int y, input logic [3:0] idx,
                            input logic done, input logic vs, input logic fs);
      logic exp_we;
      px_valid = v;
      px_x = 8'(x);
      px_y = 7'(y);
      px_index = idx;
      frame_done = done;
      vsync_start = vs;
      frame_start = fs;
      exp_we = v && x < W && y < H;
      tick();
      px_valid = 1'b0;
      frame_done = 1'b0;
      vsync_start = 1'b0;
      frame_start = 1'b0;
      chk("draw_we", {30'(fb_we), fb0_we, fb1_we}, {30'(exp_we), exp_we & m_sel, exp_we & !m_sel});
      if (exp_we) begin
         chk("draw_addr", 32'(fb_addr), 32'(y * W + x));
         chk("draw_data", 32'(fb_data), 32'(idx));
      end
      chk("draw_ready", 32'(px_ready), 32'(!done));
      chk("draw_sel", {31'(swap_done), display_sel}, {31'(0), m_sel});
      chk("draw_busy", 32'(busy), 1);
   endtask
   task automatic finish_frame();
      draw_step(1'b1, 10, 7, 4'h9, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_idle", {28'(fb_we), px_ready, busy, swap_done, display_sel}, {28'(0), 1'b0, 1'b1, 1'b0, m_sel});
      end
      vsync_start = 1'b1;
      tick();
      vsync_start = 1'b0;
      m_sel = !m_sel;
      chk("swap_pulse", {29'(swap_done), display_sel, busy, fb_we}, {29'(1), m_sel, 1'b0, 1'b0});
      tick();
      chk("swap_single", {30'(swap_done), display_sel, busy}, {30'(0), m_sel, 1'b0});
   endtask
   initial begin
      repeat (3) tick();
      chk_reset_vals("por");
      rstn = 1'b1;
      tick();
      clear_index = 4'h5;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (100) tick();
      chk("mid_clear_busy", {30'(busy), fb_we, px_ready}, {30'(1), 1'b1, 1'b0});
      #2 rstn = 1'b0;
      #1 chk_reset_vals("async_rst");
      tick();
      rstn = 1'b1;
      tick();
      chk_reset_vals("after_rst");
      run_clear(4'hA);
      draw_step(1'b1, 5, 2, 4'h3, 1'b0, 1'b0, 1'b0);
      draw_step(1'b1, 6, 2, 4'h4, 1'b0, 1'b0, 1'b0);
      draw_step(1'b1, 160, 0, 4'h1, 1'b0, 1'b0, 1'b0);
      draw_step(1'b1, 0, 120, 4'h2, 1'b0, 1'b0, 1'b0);
      draw_step(1'b1, 159, 119, 4'hF, 1'b0, 1'b0, 1'b0);
      draw_step(1'b0, 1, 1, 4'h7, 1'b0, 1'b0, 1'b0);
      draw_step(1'b1, 0, 0, 4'hE, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++)
         draw_step($urandom_range(0, 3) != 0, $urandom_range(0, 170), $urandom_range(0, 127),
                   4'($urandom), 1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      finish_frame();
      repeat (2) begin
         tick();
         chk("idle_quiet", {29'(fb_we), busy, px_ready, swap_done}, 0);
      end
      run_clear(4'h6);
      for (int i = 0; i < 40; i++)
         draw_step(1'b1, $urandom_range(0, 165), $urandom_range(0, 125), 4'($urandom), 1'b0, 1'b0, 1'b0);
      finish_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
